// File: rtl/nonce_sched_pkg.sv
// Shared types and constants for the nonce scheduler and its write arbiter.
package nonce_sched_pkg;

  localparam int unsigned MAX_CORES = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic [7:0]  nonce;
    logic [31:0] data;
  } res_entry_t;

endpackage

// File: rtl/nonce_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the granted index when the grant is consumed.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          valid_c
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] j;

  always_comb begin
    gnt_c   = '0;
    idx_c   = '0;
    valid_c = 1'b0;
    j       = '0;
    for (int i = 0; i < int'(N); i++) begin
      j = IW'((int'(ptr_q) + i) % int'(N));
      if (!valid_c && req[j]) begin
        valid_c = 1'b1;
        idx_c   = j;
      end
    end
    if (valid_c) gnt_c[idx_c] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (en && valid_c) ptr_d = IW'((int'(idx_c) + 1) % int'(N));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Hands nonces to idle hash engines, buffers each engine's H0 result and
// drains results one per cycle to memory at output_addr + nonce.
module nonce_scheduler
  import nonce_sched_pkg::*;
#(
  parameter int unsigned NUM_NONCES = 16,
  parameter int unsigned NUM_CORES  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic [15:0]             output_addr,
  output logic                    done,
  output logic [NUM_CORES-1:0]    core_start,
  output logic [NUM_CORES*32-1:0] core_nonce,
  input  logic [NUM_CORES-1:0]    core_busy,
  input  logic [NUM_CORES-1:0]    core_done,
  input  logic [NUM_CORES*32-1:0] core_h0,
  output logic                    mem_we,
  output logic [15:0]             mem_addr,
  output logic [31:0]             mem_write_data
);

  localparam int unsigned CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_NONCES + 1);

  state_e               state_q, state_d;
  logic                 done_q, done_d;
  logic [15:0]          base_q, base_d;
  logic [CNT_W-1:0]     next_nonce_q, next_nonce_d;
  logic [CNT_W-1:0]     written_cnt_q, written_cnt_d;
  logic [NUM_CORES-1:0] issued_q, issued_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [31:0]          slot_nonce_q [NUM_CORES];
  logic [31:0]          slot_nonce_d [NUM_CORES];
  res_entry_t           res_q [NUM_CORES];
  res_entry_t           res_d [NUM_CORES];
  logic                 mem_we_q, mem_we_d;
  logic [15:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_data_q, mem_data_d;

  logic [NUM_CORES-1:0] res_valid, elig, disp_oh, gnt;
  logic [CORE_W-1:0]    gnt_idx;
  logic                 gnt_vld;

  rr_arbiter #(.N(NUM_CORES)) u_wr_arb (
    .clk     (clk),
    .rst_n   (reset_n),
    .en      (state_q == RUN),
    .req     (res_valid),
    .gnt_c   (gnt),
    .idx_c   (gnt_idx),
    .valid_c (gnt_vld)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (written_cnt_q == CNT_W'(NUM_NONCES)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Lowest-index eligible engine; a pending or in-flight slot keeps it out.
  always_comb begin
    for (int k = 0; k < int'(NUM_CORES); k++) res_valid[k] = res_q[k].valid;
    elig    = ~core_busy & ~issued_q & ~res_valid & ~core_start_q;
    disp_oh = '0;
    if (state_q == RUN && next_nonce_q < CNT_W'(NUM_NONCES))
      disp_oh = elig & (~elig + NUM_CORES'(1));
  end

  // Output / datapath next-state
  always_comb begin
    done_d        = (state_d == IDLE);
    base_d        = base_q;
    next_nonce_d  = next_nonce_q;
    written_cnt_d = written_cnt_q;
    issued_d      = issued_q;
    core_start_d  = '0;
    slot_nonce_d  = slot_nonce_q;
    res_d         = res_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d        = output_addr;
          next_nonce_d  = '0;
          written_cnt_d = '0;
          issued_d      = '0;
          for (int k = 0; k < int'(NUM_CORES); k++) res_d[k].valid = 1'b0;
        end
      end
      RUN: begin
        if (disp_oh != '0) begin
          core_start_d = disp_oh;
          issued_d     = issued_d | disp_oh;
          next_nonce_d = next_nonce_q + CNT_W'(1);
          for (int k = 0; k < int'(NUM_CORES); k++)
            if (disp_oh[k]) slot_nonce_d[k] = 32'(next_nonce_q);
        end
        // Grant needs valid_q=1 and capture needs valid_q=0, so they never collide.
        if (gnt_vld) begin
          mem_we_d             = 1'b1;
          mem_addr_d           = base_q + 16'(res_q[gnt_idx].nonce);
          mem_data_d           = res_q[gnt_idx].data;
          res_d[gnt_idx].valid = 1'b0;
          issued_d             = issued_d & ~gnt;
          written_cnt_d        = written_cnt_q + CNT_W'(1);
        end
        for (int k = 0; k < int'(NUM_CORES); k++) begin
          if (core_done[k] && issued_q[k] && !res_q[k].valid) begin
            res_d[k].valid = 1'b1;
            res_d[k].nonce = 8'(slot_nonce_q[k]);
            res_d[k].data  = core_h0[32*k +: 32];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_q        <= 1'b1;
      base_q        <= '0;
      next_nonce_q  <= '0;
      written_cnt_q <= '0;
      issued_q      <= '0;
      core_start_q  <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      for (int k = 0; k < int'(NUM_CORES); k++) begin
        slot_nonce_q[k] <= '0;
        res_q[k]        <= '0;
      end
    end else begin
      done_q        <= done_d;
      base_q        <= base_d;
      next_nonce_q  <= next_nonce_d;
      written_cnt_q <= written_cnt_d;
      issued_q      <= issued_d;
      core_start_q  <= core_start_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      for (int k = 0; k < int'(NUM_CORES); k++) begin
        slot_nonce_q[k] <= slot_nonce_d[k];
        res_q[k]        <= res_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < int'(NUM_CORES); k++) core_nonce[32*k +: 32] = slot_nonce_q[k];
  end

  assign done           = done_q;
  assign core_start     = core_start_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_data_q;

endmodule
